// File: rtl/pixel_hex_tx.sv
// ---------------------------------------------------------------------------
// pixel_hex_tx
//
// Turns a stream of 24-bit RGB pixels into ASCII hex text, six characters per
// pixel in the order R[7:4] R[3:0] G[7:4] G[3:0] B[7:4] B[3:0]. This is the
// same text that "%02x%02x%02x" would print. Only one pixel is in flight at a
// time. Both sides use a valid/ready handshake.
//
// Optional feature macro: PIXHEX_NEWLINE_EN
//   defined   : after every LINE_PIXELS pixels, a newline byte (8'h0A) is sent
//               after that pixel's sixth character.
//   undefined : pixels are sent back to back with no separator bytes, and
//               LINE_PIXELS has no effect.
//
// Parameters
//   UPPERCASE    1: hex letters A-F; 0: hex letters a-f
//   LINE_PIXELS  pixels per text line (newline build only), 1..65535
//   CNT_W        width of pix_cnt_o
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   pix_valid_i  a pixel is present on pix_rgb_i
//   pix_rgb_i    {R,G,B}, with R in [23:16]
//   pix_ready_o  block can accept a pixel (registered)
//   ch_valid_o   ch_data_o holds a valid ASCII byte (registered)
//   ch_data_o    ASCII character (registered)
//   ch_ready_i   sink accepts ch_data_o this cycle
//   busy_o       high while a pixel is latched and not yet fully sent
//   pix_cnt_o    pixels fully sent since reset; wraps to zero after all-ones
// ---------------------------------------------------------------------------
module pixel_hex_tx #(
    parameter int UPPERCASE   = 0,
    parameter int LINE_PIXELS = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pix_valid_i,
    input  logic [23:0]      pix_rgb_i,
    output logic             pix_ready_o,
    output logic             ch_valid_o,
    output logic [7:0]       ch_data_o,
    input  logic             ch_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] pix_cnt_o
);

`ifdef PIXHEX_NEWLINE_EN
    typedef enum logic [1:0] {IDLE, SEND, NL} state_e;
    localparam logic [15:0] LINE_LAST = 16'(LINE_PIXELS - 1);
`else
    typedef enum logic [1:0] {IDLE, SEND} state_e;
    logic unused_line_pixels;
    assign unused_line_pixels = (LINE_PIXELS != 0);
`endif

    localparam logic [7:0] LETTER_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    state_e            state_q, state_d;
    logic [2:0]        char_idx_q, char_idx_d;
    logic [23:0]       pix_q, pix_d;
    logic              pix_ready_q, pix_ready_d;
    logic              ch_valid_q, ch_valid_d;
    logic [7:0]        ch_data_q, ch_data_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              go_idle;
`ifdef PIXHEX_NEWLINE_EN
    logic [15:0]       line_cnt_q, line_cnt_d;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return LETTER_BASE + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [3:0] nibble_at(input logic [23:0] p, input logic [2:0] idx);
        case (idx)
            3'd0:    return p[23:20];
            3'd1:    return p[19:16];
            3'd2:    return p[15:12];
            3'd3:    return p[11:8];
            3'd4:    return p[7:4];
            3'd5:    return p[3:0];
            default: return 4'h0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        char_idx_d  = char_idx_q;
        pix_d       = pix_q;
        pix_ready_d = pix_ready_q;
        ch_valid_d  = ch_valid_q;
        ch_data_d   = ch_data_q;
        busy_d      = busy_q;
        pix_cnt_d   = pix_cnt_q;
        go_idle     = 1'b0;
`ifdef PIXHEX_NEWLINE_EN
        line_cnt_d  = line_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // pix_ready rises one edge after reset is released.
                pix_ready_d = 1'b1;
                if (pix_valid_i && pix_ready_q) begin
                    pix_d       = pix_rgb_i;
                    pix_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    ch_valid_d  = 1'b1;
                    ch_data_d   = hex_ascii(pix_rgb_i[23:20]);
                    char_idx_d  = 3'd0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (ch_ready_i) begin
                    if (char_idx_q == 3'd5) begin
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
`ifdef PIXHEX_NEWLINE_EN
                        if (line_cnt_q == LINE_LAST) begin
                            line_cnt_d = '0;
                            ch_data_d  = 8'h0A;
                            state_d    = NL;
                        end else begin
                            line_cnt_d = line_cnt_q + 16'd1;
                            go_idle    = 1'b1;
                        end
`else
                        go_idle = 1'b1;
`endif
                    end else begin
                        char_idx_d = char_idx_q + 3'd1;
                        ch_data_d  = hex_ascii(nibble_at(pix_q, char_idx_q + 3'd1));
                    end
                end
            end
`ifdef PIXHEX_NEWLINE_EN
            NL: begin
                if (ch_ready_i) begin
                    go_idle = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pixel finished: the output drops and a new pixel can be taken
        // on the very next edge, which gives 7 cycles per pixel.
        if (go_idle) begin
            state_d     = IDLE;
            ch_valid_d  = 1'b0;
            pix_ready_d = 1'b1;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            char_idx_q  <= 3'd0;
            pix_q       <= 24'h0;
            pix_ready_q <= 1'b0;
            ch_valid_q  <= 1'b0;
            ch_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            pix_cnt_q   <= '0;
`ifdef PIXHEX_NEWLINE_EN
            line_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            char_idx_q  <= char_idx_d;
            pix_q       <= pix_d;
            pix_ready_q <= pix_ready_d;
            ch_valid_q  <= ch_valid_d;
            ch_data_q   <= ch_data_d;
            busy_q      <= busy_d;
            pix_cnt_q   <= pix_cnt_d;
`ifdef PIXHEX_NEWLINE_EN
            line_cnt_q  <= line_cnt_d;
`endif
        end
    end

    assign pix_ready_o = pix_ready_q;
    assign ch_valid_o  = ch_valid_q;
    assign ch_data_o   = ch_data_q;
    assign busy_o      = busy_q;
    assign pix_cnt_o   = pix_cnt_q;

endmodule
